countdown99: RTL and testbench
==============================

COUNTDOWN99 -- requirements
Module: countdown99

Interface
REQ-001 SHALL have parameter PRESCALE, default 1, clk cycles per decrement while running (legal 1..65535).
REQ-002 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port load  input  1  single-cycle request to load load_val.
REQ-005 SHALL have port load_val  input  7  start value, unsigned.
REQ-006 SHALL have port start  input  1  begin or resume counting.
REQ-007 SHALL have port pause  input  1  suspend counting.
REQ-008 SHALL have port count  output  7  current value, 0..99, registered.
REQ-009 SHALL have port tens  output  4  BCD tens digit of count.
REQ-010 SHALL have port ones  output  4  BCD ones digit of count.
REQ-011 SHALL have port running  output  1  high while state is RUN.
REQ-012 SHALL have port done  output  1  registered one-cycle pulse on reaching 0.

Function
REQ-013 SHALL implement states IDLE, RUN, PAUSED, DONE.
REQ-014 SHALL, on load in any state: count and reload register <= min(load_val, 99); prescaler <= 0; state <= IDLE. Load has priority over start/pause.
REQ-015 SHALL give pause priority over start when both are high in the same cycle.
REQ-016 IDLE: start with count != 0 -> RUN; start with count == 0 ignored, stays IDLE.
REQ-017 RUN: pause -> PAUSED, count and prescaler frozen.
REQ-018 PAUSED: start -> RUN, prescaler resumes from its frozen value (no lost partial period).
REQ-019 DONE: start and pause ignored; only load or reset leave DONE.
REQ-020 RUN: prescaler counts 0..PRESCALE-1; on the cycle it equals PRESCALE-1, count decrements by 1 and prescaler wraps to 0. First decrement occurs PRESCALE cycles after the start edge.
REQ-021 SHALL assert done for exactly one cycle, on the same edge count transitions 1 -> 0; done never asserts otherwise.
REQ-022 SHALL never let count underflow below 0 or exceed 99.
REQ-023 tens = count / 10, ones = count % 10, combinational from count, always 0..9.
REQ-024 running SHALL be combinational decode of state == RUN.

Reset
REQ-025 SHALL, while reset_n is low, force count = 0, reload register = 0, prescaler = 0, done = 0, state = IDLE, independent of clk.
REQ-026 SHALL, on reset_n assertion mid-RUN, abort immediately with no done pulse; after release stays IDLE until load/start.

Configuration
REQ-027 Macro COUNTDOWN_AUTORELOAD_EN SHALL select the behaviour at count reaching 0.
REQ-028 Without COUNTDOWN_AUTORELOAD_EN: on the 1 -> 0 transition state <= DONE, count holds 0.
REQ-029 With COUNTDOWN_AUTORELOAD_EN: state stays RUN; at the next prescaler terminal, count <= reload register and counting continues; done pulses every time 0 is reached; pause still applies; DONE state unreachable.

Verification
REQ-030 PRESCALE=1, load 5, start -> count 4,3,2,1,0 on successive cycles; done high only on the 0 cycle; state DONE, running 0.
REQ-031 load_val=120 -> count=99, tens=9, ones=9; load_val=0 then start -> stays IDLE, running 0, no done.
REQ-032 PRESCALE=3, load 2, start, pause after 2 cycles for 5 cycles, start -> first decrement 1 cycle after resume, count 1 then 0 three cycles later.
REQ-033 Same-cycle start+pause in RUN -> PAUSED; same-cycle load+start in RUN -> IDLE with new value, not running.
REQ-034 reset_n low for 1 cycle while count=3 in RUN -> count 0, IDLE, done never pulses; async (mid-cycle) assertion takes effect before next clk edge.
REQ-035 With COUNTDOWN_AUTORELOAD_EN, PRESCALE=1, load 2, start -> count 1,0,2,1,0,2...; done pulses every 3rd cycle; running stays 1.

Source files
------------

// File: rtl/countdown99.sv
// countdown99 - loadable 0..99 down-counter with BCD digit outputs.
//
// Counts down once every PRESCALE clocks while running and pulses done when
// the count reaches 0. States: IDLE, RUN, PAUSED, DONE.
//
// Optional feature macro: COUNTDOWN_AUTORELOAD_EN
//   undefined : reaching 0 moves to DONE and the count holds at 0.
//   defined   : the count stays in RUN and reloads from the reload register at
//               the next prescaler terminal. DONE is never entered.
//
// Parameters:
//   PRESCALE  clocks per decrement while running (1..65535)
// Ports:
//   clk       sole clock, rising edge
//   reset_n   asynchronous active-low reset
//   load      load load_val, saturated to 99. Goes to IDLE. Beats start/pause.
//   load_val  7-bit unsigned start value
//   start     begin or resume counting
//   pause     suspend counting. Beats start in the same cycle.
//   count     registered current value, 0..99
//   tens      BCD tens digit of count
//   ones      BCD ones digit of count
//   running   high while in RUN
//   done      registered one-cycle pulse on the 1 -> 0 transition
module countdown99 #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [6:0] load_val,
    input  logic       start,
    input  logic       pause,
    output logic [6:0] count,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       running,
    output logic       done
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StRun    = 2'd1;
    localparam logic [1:0] StPaused = 2'd2;
    localparam logic [1:0] StDone   = 2'd3;

    localparam logic [15:0] PresclLast = 16'(PRESCALE - 1);

    logic [1:0]  state_q, state_d;
    logic [6:0]  count_q, count_d;
    logic [6:0]  reload_q, reload_d;
    logic [15:0] presc_q, presc_d;
    logic        done_q, done_d;

    logic [6:0]  load_sat;

    assign load_sat = (load_val > 7'd99) ? 7'd99 : load_val;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        presc_d  = presc_q;
        done_d   = 1'b0;

        if (load) begin
            count_d  = load_sat;
            reload_d = load_sat;
            presc_d  = 16'd0;
            state_d  = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    // A zero count has nothing to count, so start is dropped.
                    if (start && !pause && (count_q != 7'd0)) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (pause) begin
                        // Count and prescaler freeze so a resume loses no partial period.
                        state_d = StPaused;
                    end else if (presc_q == PresclLast) begin
                        presc_d = 16'd0;
`ifdef COUNTDOWN_AUTORELOAD_EN
                        // Zero is held for one full prescale period before reloading.
                        if (count_q == 7'd0) begin
                            count_d = reload_q;
                        end else begin
                            count_d = count_q - 7'd1;
                        end
                        if (count_q == 7'd1) begin
                            done_d = 1'b1;
                        end
`else
                        if (count_q != 7'd0) begin
                            count_d = count_q - 7'd1;
                        end
                        if (count_q == 7'd1) begin
                            done_d  = 1'b1;
                            state_d = StDone;
                        end
`endif
                    end else begin
                        presc_d = presc_q + 16'd1;
                    end
                end
                StPaused: begin
                    if (start && !pause) begin
                        state_d = StRun;
                    end
                end
                StDone: begin
                    // Only load or reset leave DONE.
                    state_d = StDone;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            count_q  <= 7'd0;
            reload_q <= 7'd0;
            presc_q  <= 16'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            presc_q  <= presc_d;
            done_q   <= done_d;
        end
    end

    assign count   = count_q;
    assign tens    = 4'(count_q / 7'd10);
    assign ones    = 4'(count_q % 7'd10);
    assign running = (state_q == StRun);
    assign done    = done_q;

endmodule

// File: tb/tb_countdown99.sv
// Directed bench for countdown99. Two instances share the inputs: u_dut1
// (PRESCALE=1) and u_dut3 (PRESCALE=3). Each test checks only the
// instance it is about.
module tb_countdown99;

    logic       clk;
    logic       reset_n;
    logic       load;
    logic [6:0] load_val;
    logic       start;
    logic       pause;

    logic [6:0] count1, count3;
    logic [3:0] tens1, ones1, tens3, ones3;
    logic       running1, running3, done1, done3;

    int cmp_cnt = 0;
    int err_cnt = 0;

    countdown99 #(.PRESCALE(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .load(load), .load_val(load_val),
        .start(start), .pause(pause), .count(count1), .tens(tens1),
        .ones(ones1), .running(running1), .done(done1)
    );

    countdown99 #(.PRESCALE(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .load(load), .load_val(load_val),
        .start(start), .pause(pause), .count(count3), .tens(tens3),
        .ones(ones3), .running(running3), .done(done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [6:0] v);
        load = 1'b1; load_val = v;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; load = 1'b0; load_val = 7'd0; start = 1'b0; pause = 1'b0;
        #23;
        reset_n = 1'b1;
        tick();
        cmp_cnt++; if (count1 !== 7'd0) begin err_cnt++; $display("FAIL reset_count: got %0d want 0", count1); end
        cmp_cnt++; if (running1 !== 1'b0 || running3 !== 1'b0) begin err_cnt++; $display("FAIL reset_running: got %b/%b want 0/0", running1, running3); end
        cmp_cnt++; if (done1 !== 1'b0 || done3 !== 1'b0) begin err_cnt++; $display("FAIL reset_done: got %b/%b want 0/0", done1, done3); end
        cmp_cnt++; if (tens1 !== 4'd0 || ones1 !== 4'd0) begin err_cnt++; $display("FAIL reset_bcd: got %0d%0d want 00", tens1, ones1); end
    endtask

    task automatic test_countdown;
`ifdef COUNTDOWN_AUTORELOAD_EN
        int exp_seq[6] = '{1, 0, 2, 1, 0, 2};
        do_load(7'd2);
`else
        int exp_seq[5] = '{4, 3, 2, 1, 0};
        do_load(7'd5);
        cmp_cnt++; if (count1 !== 7'd5 || running1 !== 1'b0) begin err_cnt++; $display("FAIL load5: got count %0d run %b want 5 0", count1, running1); end
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        cmp_cnt++; if (running1 !== 1'b1) begin err_cnt++; $display("FAIL start_running: got %b want 1", running1); end
        foreach (exp_seq[i]) begin
            tick();
            cmp_cnt++; if (count1 !== 7'(exp_seq[i])) begin err_cnt++; $display("FAIL cd_count[%0d]: got %0d want %0d", i, count1, exp_seq[i]); end
            cmp_cnt++; if (done1 !== (exp_seq[i] == 0)) begin err_cnt++; $display("FAIL cd_done[%0d]: got %b want %b", i, done1, exp_seq[i] == 0); end
`ifdef COUNTDOWN_AUTORELOAD_EN
            cmp_cnt++; if (running1 !== 1'b1) begin err_cnt++; $display("FAIL cd_running[%0d]: got %b want 1", i, running1); end
`else
            cmp_cnt++; if (running1 !== (exp_seq[i] != 0)) begin err_cnt++; $display("FAIL cd_running[%0d]: got %b want %b", i, running1, exp_seq[i] != 0); end
`endif
        end
`ifndef COUNTDOWN_AUTORELOAD_EN
        // DONE ignores start and never pulses again.
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        cmp_cnt++; if (count1 !== 7'd0 || running1 !== 1'b0 || done1 !== 1'b0) begin
            err_cnt++; $display("FAIL done_hold: got count %0d run %b done %b want 0 0 0", count1, running1, done1);
        end
`endif
    endtask

    task automatic test_saturate;
        do_load(7'd120);
        cmp_cnt++; if (count1 !== 7'd99) begin err_cnt++; $display("FAIL sat_count: got %0d want 99", count1); end
        cmp_cnt++; if (tens1 !== 4'd9 || ones1 !== 4'd9) begin err_cnt++; $display("FAIL sat_bcd: got %0d%0d want 99", tens1, ones1); end
        do_load(7'd57);
        cmp_cnt++; if (tens1 !== 4'd5 || ones1 !== 4'd7) begin err_cnt++; $display("FAIL bcd57: got %0d%0d want 57", tens1, ones1); end
        do_load(7'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cmp_cnt++; if (running1 !== 1'b0 || done1 !== 1'b0 || count1 !== 7'd0) begin
                err_cnt++; $display("FAIL zero_start[%0d]: got run %b done %b count %0d want 0 0 0", i, running1, done1, count1);
            end
            tick();
        end
    endtask

    task automatic test_prescale;
        do_load(7'd2);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        cmp_cnt++; if (count3 !== 7'd2 || running3 !== 1'b1) begin err_cnt++; $display("FAIL ps_prepause: got count %0d run %b want 2 1", count3, running3); end
        pause = 1'b1;
        repeat (5) tick();
        pause = 1'b0;
        cmp_cnt++; if (count3 !== 7'd2 || running3 !== 1'b0) begin err_cnt++; $display("FAIL ps_paused: got count %0d run %b want 2 0", count3, running3); end
        start = 1'b1;
        tick();
        start = 1'b0;
        cmp_cnt++; if (count3 !== 7'd2 || running3 !== 1'b1) begin err_cnt++; $display("FAIL ps_resume: got count %0d run %b want 2 1", count3, running3); end
        tick();
        cmp_cnt++; if (count3 !== 7'd1) begin err_cnt++; $display("FAIL ps_first_dec: got %0d want 1", count3); end
        tick();
        tick();
        cmp_cnt++; if (count3 !== 7'd1 || done3 !== 1'b0) begin err_cnt++; $display("FAIL ps_hold1: got count %0d done %b want 1 0", count3, done3); end
        tick();
        cmp_cnt++; if (count3 !== 7'd0 || done3 !== 1'b1) begin err_cnt++; $display("FAIL ps_zero: got count %0d done %b want 0 1", count3, done3); end
    endtask

    task automatic test_priority;
        do_load(7'd9);
        start = 1'b1;
        tick();
        start = 1'b1; pause = 1'b1;
        tick();
        start = 1'b0; pause = 1'b0;
        cmp_cnt++; if (running1 !== 1'b0 || count1 !== 7'd9) begin err_cnt++; $display("FAIL pri_pause: got run %b count %0d want 0 9", running1, count1); end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        cmp_cnt++; if (count1 !== 7'd8 || running1 !== 1'b1) begin err_cnt++; $display("FAIL pri_resume: got count %0d run %b want 8 1", count1, running1); end
        load = 1'b1; load_val = 7'd30; start = 1'b1;
        tick();
        load = 1'b0; start = 1'b0;
        cmp_cnt++; if (count1 !== 7'd30 || running1 !== 1'b0) begin err_cnt++; $display("FAIL pri_load: got count %0d run %b want 30 0", count1, running1); end
        tick();
        cmp_cnt++; if (count1 !== 7'd30 || running1 !== 1'b0) begin err_cnt++; $display("FAIL pri_idle: got count %0d run %b want 30 0", count1, running1); end
    endtask

    task automatic test_async_reset;
        do_load(7'd5);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        cmp_cnt++; if (count1 !== 7'd3 || running1 !== 1'b1) begin err_cnt++; $display("FAIL ar_pre: got count %0d run %b want 3 1", count1, running1); end
        #3;
        reset_n = 1'b0;
        #1;
        cmp_cnt++; if (count1 !== 7'd0 || running1 !== 1'b0 || done1 !== 1'b0) begin
            err_cnt++; $display("FAIL ar_async: got count %0d run %b done %b want 0 0 0", count1, running1, done1);
        end
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            cmp_cnt++; if (count1 !== 7'd0 || running1 !== 1'b0 || done1 !== 1'b0) begin
                err_cnt++; $display("FAIL ar_post[%0d]: got count %0d run %b done %b want 0 0 0", i, count1, running1, done1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_saturate();
        test_prescale();
        test_priority();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
